// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL    = 1'b1;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   MIN_DATA_BITS = 5;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period counter: counts 1..rollover_val and wraps, flagging the last clock of each bit.
module tx_bit_timer #(
    parameter int PERIOD_BITS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   count_enable,
    input  logic [PERIOD_BITS-1:0] rollover_val,
    output logic [PERIOD_BITS-1:0] count_out,
    output logic                   rollover_flag
);

    // A clear that coincides with an enable makes that clock the first count of a new bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= count_enable ? PERIOD_BITS'(1) : '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= PERIOD_BITS'(1);
            end else begin
                count_out <= count_out + PERIOD_BITS'(1);
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, 5..MAX_DATA_BITS data bits LSB first, one stop bit.
module uart_tx_block
    import uart_tx_pkg::*;
#(
    parameter int PERIOD_BITS   = 10,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    input  logic                     tx_start,
    input  logic [3:0]               data_size,
    input  logic [PERIOD_BITS-1:0]   bit_period,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam logic [3:0] MIN_SIZE = 4'(MIN_DATA_BITS);
    localparam logic [3:0] MAX_SIZE = 4'(MAX_DATA_BITS);

    tx_state_t                state;
    logic [MAX_DATA_BITS-1:0] shift_reg;
    logic [3:0]               bit_idx;
    logic [3:0]               frame_size;
    logic [PERIOD_BITS-1:0]   frame_period;
    logic [3:0]               size_clamped;
    logic [PERIOD_BITS-1:0]   period_clamped;
    logic [PERIOD_BITS-1:0]   bit_count;
    logic                     rollover_flag;
    logic                     bit_end;
    logic                     timer_clear;
    logic                     timer_enable;

    always_comb begin
        size_clamped = data_size;
        if (data_size < MIN_SIZE) begin
            size_clamped = MIN_SIZE;
        end else if (data_size > MAX_SIZE) begin
            size_clamped = MAX_SIZE;
        end
    end

    assign period_clamped = (bit_period == '0) ? PERIOD_BITS'(1) : bit_period;

    // The timer idles at zero and starts counting on the accept clock itself.
    assign timer_clear  = (state == IDLE);
    assign timer_enable = (state != IDLE) || tx_start;
    assign bit_end      = rollover_flag && (bit_count != '0);

    tx_bit_timer #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (timer_clear),
        .count_enable (timer_enable),
        .rollover_val (frame_period),
        .count_out    (bit_count),
        .rollover_flag(rollover_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_idx      <= '0;
            frame_size   <= MIN_SIZE;
            frame_period <= PERIOD_BITS'(1);
            serial_out   <= IDLE_LEVEL;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift_reg    <= tx_data;
                        frame_size   <= size_clamped;
                        frame_period <= period_clamped;
                        bit_idx      <= '0;
                        serial_out   <= START_BIT;
                        tx_busy      <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 4'd1;
                        if (bit_idx == frame_size - 4'd1) begin
                            serial_out <= STOP_BIT;
                            state      <= STOP;
                        end else begin
                            serial_out <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        serial_out <= IDLE_LEVEL;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    serial_out <= IDLE_LEVEL;
                    tx_busy    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_block.sv
// Self-checking bench for uart_tx_block using a frame-level reference model.
module tb_uart_tx_block;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] data_size;
    logic [9:0] bit_period;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    int   total = 0;
    int   bad   = 0;
    logic exp_line[$];
    logic got_line[$];
    int   got_busy;
    logic got_done;
    logic got_timeout;

    uart_tx_block #(
        .PERIOD_BITS  (10),
        .MAX_DATA_BITS(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .data_size (data_size),
        .bit_period(bit_period),
        .serial_out(serial_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the line level for every busy clock of one frame.
    task automatic model_frame(input logic [7:0] d, input int size, input int period);
        int n;
        int p;
        n = (size < 5) ? 5 : ((size > 8) ? 8 : size);
        p = (period < 1) ? 1 : period;
        exp_line.delete();
        repeat (p) exp_line.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (p) exp_line.push_back(d[i]);
        end
        repeat (p) exp_line.push_back(1'b1);
    endtask

    function automatic int line_diff();
        int diffs;
        int n;
        diffs = 0;
        n = (got_line.size() < exp_line.size()) ? got_line.size() : exp_line.size();
        for (int i = 0; i < n; i++) begin
            if (got_line[i] !== exp_line[i]) diffs++;
        end
        diffs += (got_line.size() > exp_line.size()) ? got_line.size() - exp_line.size()
                                                      : exp_line.size() - got_line.size();
        return diffs;
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic [3:0] size, input logic [9:0] period);
        tx_data    = d;
        data_size  = size;
        bit_period = period;
        tx_start   = 1'b1;
        step();
        tx_start   = 1'b0;
    endtask

    // Records the line while busy; optionally disturbs inputs at a given busy clock.
    task automatic capture(input int poke_at, input logic poke_start, input logic [7:0] pd,
                           input logic [3:0] ps, input logic [9:0] pp, input int drop_at);
        got_line.delete();
        got_busy    = 0;
        got_timeout = 1'b0;
        while (tx_busy === 1'b1) begin
            got_line.push_back(serial_out);
            got_busy++;
            if (got_busy == poke_at) begin
                tx_start   = poke_start;
                tx_data    = pd;
                data_size  = ps;
                bit_period = pp;
            end
            if (got_busy == drop_at) tx_start = 1'b0;
            step();
            if (got_busy >= 400) begin
                got_timeout = 1'b1;
                break;
            end
        end
        got_done = tx_done;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        tx_start   = 1'b1;
        tx_data    = 8'h3C;
        data_size  = 4'd8;
        bit_period = 10'd2;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (serial_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_serial: actual=%b required=1", serial_out); end
            total++;
            if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: actual=%b required=0", tx_busy); end
            total++;
            if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: actual=%b required=0", tx_done); end
        end
        rst      = 1'b0;
        tx_start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL after_reset_idle: actual=%b required=100", {serial_out, tx_busy, tx_done});
            end
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] d;
        logic [3:0] s;
        logic [9:0] p;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                d = 8'hA5; s = 4'd8; p = 10'd4;
            end else begin
                d = 8'($urandom);
                s = 4'($urandom_range(15, 0));
                p = 10'($urandom_range(5, 0));
            end
            model_frame(d, int'(s), int'(p));
            start_frame(d, s, p);
            capture(-1, 1'b0, 8'h00, 4'd0, 10'd0, -1);
            total++;
            if (line_diff() != 0) begin
                bad++;
                $display("[TB] FAIL frame%0d_line: actual len=%0d diffs=%0d required len=%0d diffs=0",
                         k, got_line.size(), line_diff(), exp_line.size());
            end
            total++;
            if (got_busy != exp_line.size()) begin
                bad++;
                $display("[TB] FAIL frame%0d_busy: actual=%0d required=%0d", k, got_busy, exp_line.size());
            end
            total++;
            if (got_done !== 1'b1 || got_timeout) begin
                bad++;
                $display("[TB] FAIL frame%0d_done: actual=%b required=1", k, got_done);
            end
        end
        step();
        total++;
        if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL done_one_cycle: actual=%b required=0", tx_done); end
    endtask

    task automatic test_short_frame();
        logic [3:0] sizes[2];
        sizes[0] = 4'd5;
        sizes[1] = 4'd2;
        for (int k = 0; k < 2; k++) begin
            model_frame(8'hFF, int'(sizes[k]), 1);
            start_frame(8'hFF, sizes[k], 10'd1);
            capture(-1, 1'b0, 8'h00, 4'd0, 10'd0, -1);
            total++;
            if (line_diff() != 0) begin
                bad++;
                $display("[TB] FAIL short%0d_line: actual len=%0d diffs=%0d required len=%0d diffs=0",
                         k, got_line.size(), line_diff(), exp_line.size());
            end
            total++;
            if (got_busy != 7) begin bad++; $display("[TB] FAIL short%0d_busy: actual=%0d required=7", k, got_busy); end
            total++;
            if (got_done !== 1'b1) begin bad++; $display("[TB] FAIL short%0d_done: actual=%b required=1", k, got_done); end
        end
    endtask

    task automatic test_busy_start_ignored();
        logic [7:0] d;
        d = 8'($urandom);
        model_frame(d, 8, 3);
        start_frame(d, 4'd8, 10'd3);
        capture(9, 1'b1, ~d, 4'd5, 10'd1, 10);
        total++;
        if (line_diff() != 0 || got_busy != 30) begin
            bad++;
            $display("[TB] FAIL busy_start_frame: actual busy=%0d diffs=%0d required busy=30 diffs=0",
                     got_busy, line_diff());
        end
        total++;
        if (got_done !== 1'b1) begin bad++; $display("[TB] FAIL busy_start_done: actual=%b required=1", got_done); end
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_extra: actual=%b required=0", tx_busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[4];
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        tx_data    = d[0];
        data_size  = 4'd8;
        bit_period = 10'd2;
        tx_start   = 1'b1;
        step();
        for (int f = 0; f < 3; f++) begin
            model_frame(d[f], 8, 2);
            capture(1, 1'b1, d[f+1], 4'd8, 10'd2, (f == 2) ? 1 : -1);
            total++;
            if (line_diff() != 0 || got_busy != 20) begin
                bad++;
                $display("[TB] FAIL b2b%0d_frame: actual busy=%0d diffs=%0d required busy=20 diffs=0",
                         f, got_busy, line_diff());
            end
            total++;
            if (got_done !== 1'b1 || serial_out !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b%0d_gap: actual done=%b line=%b required done=1 line=1", f, got_done, serial_out);
            end
            step();
            total++;
            if (tx_busy !== ((f < 2) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("[TB] FAIL b2b%0d_next: actual busy=%b required=%b", f, tx_busy, (f < 2));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'($urandom);
        start_frame(d, 4'd8, 10'd3);
        repeat (13) step();
        total++;
        if (serial_out !== d[3]) begin bad++; $display("[TB] FAIL mid_bit3: actual=%b required=%b", serial_out, d[3]); end
        rst = 1'b1;
        step();
        total++;
        if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL mid_reset: actual=%b required=100", {serial_out, tx_busy, tx_done});
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL mid_release: actual=%b required=100", {serial_out, tx_busy, tx_done});
            end
        end
        d = 8'($urandom);
        model_frame(d, 7, 2);
        start_frame(d, 4'd7, 10'd2);
        capture(-1, 1'b0, 8'h00, 4'd0, 10'd0, -1);
        total++;
        if (line_diff() != 0 || got_busy != 18 || got_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL post_reset_frame: actual busy=%0d diffs=%0d done=%b required busy=18 diffs=0 done=1",
                     got_busy, line_diff(), got_done);
        end
    endtask

    task automatic test_period_zero_and_change();
        logic [7:0] d;
        logic [3:0] s;
        d = 8'($urandom);
        s = 4'($urandom_range(8, 5));
        model_frame(d, int'(s), 0);
        start_frame(d, s, 10'd0);
        capture(-1, 1'b0, 8'h00, 4'd0, 10'd0, -1);
        total++;
        if (line_diff() != 0 || got_busy != int'(s) + 2) begin
            bad++;
            $display("[TB] FAIL period0_frame: actual busy=%0d diffs=%0d required busy=%0d diffs=0",
                     got_busy, line_diff(), int'(s) + 2);
        end
        d = 8'($urandom);
        model_frame(d, 6, 2);
        start_frame(d, 4'd6, 10'd2);
        capture(3, 1'b0, ~d, 4'd8, 10'd0, -1);
        total++;
        if (line_diff() != 0 || got_busy != 16 || got_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL change_frame: actual busy=%0d diffs=%0d done=%b required busy=16 diffs=0 done=1",
                     got_busy, line_diff(), got_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_busy_start_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_period_zero_and_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
